// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_pkg
//  Description : Shared types and constants for the 7-segment scan driver:
//                scan FSM state encoding, inactive drive levels and the
//                active-low anode select helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_driver_pkg;

    // Scan FSM states, explicitly encoded
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Widest display the anode helpers must cover
    localparam int unsigned c_max_digits = 8;

    // Common-anode drive polarity: everything is active-low at the pins
    localparam logic       c_an_on   = 1'b0;
    localparam logic [6:0] c_seg_off = 7'h7F;
    localparam logic       c_dp_off  = 1'b1;

    // All anodes released
    function automatic logic [c_max_digits-1:0] an_off();
        an_off = '1;
    endfunction

    // Exactly one anode pulled low at position idx
    function automatic logic [c_max_digits-1:0] an_select_n(input logic [2:0] idx);
        logic [c_max_digits-1:0] v_sel;
        v_sel      = an_off();
        v_sel[idx] = c_an_on;
        an_select_n = v_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_scan_timer
//  Description : Digit slot timer. Each slot is SCAN_DIV cycles: BLANK_CYC
//                cycles with all anodes off, then the remainder showing the
//                current digit. Advances the digit index at the end of every
//                slot and flags the N_DIGITS-1 -> 0 wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver_scan_timer
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 8,
    localparam int unsigned IDX_W    = $clog2(N_DIGITS),
    localparam int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             show,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] c_slot_last  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(N_DIGITS - 1);

    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_end;

    assign w_slot_end = (r_state == ST_SHOW) && (r_cnt == c_slot_last);

    // Slot counter, BLANK/SHOW sequencing and digit index; disabling parks in BLANK at count 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (!en) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_blank_last) begin
                        r_state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_slot_end) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign idx  = r_idx;
    assign show = (r_state == ST_SHOW);
    assign wrap = en && w_slot_end && (r_idx == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Captures segment pattern + decimal point strobes into an
//                N_DIGITS-deep history (newest on digit 0) and scans it onto
//                a common-anode 7-segment display with per-slot blanking.
//                All pin drives are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                load,
    input  logic [6:0]          seg_in,
    input  logic                dp_in,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [N_DIGITS-1:0] an_n,
    output logic                frame_tick
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [6:0]          r_dig [N_DIGITS];
    logic                r_dp  [N_DIGITS];
    logic [IDX_W-1:0]    w_idx;
    logic                w_show;
    logic                w_wrap;
    logic                w_drive;
    logic [c_max_digits-1:0] w_an_sel_full;
    logic [c_max_digits-1:0] w_an_off_full;
    logic [6:0]          r_seg_n;
    logic                r_dp_n;
    logic [N_DIGITS-1:0] r_an_n;
    logic                r_frame_tick;

    seg_scan_driver_scan_timer #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .idx   (w_idx),
        .show  (w_show),
        .wrap  (w_wrap)
    );

    // Gating with en makes the display go dark on the first edge en is seen low
    assign w_drive       = w_show && en;
    assign w_an_sel_full = an_select_n(3'(w_idx));
    assign w_an_off_full = an_off();

    // Digit history: clear wins over load; load shifts toward the oldest digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_dig[i] <= '0;
                r_dp[i]  <= 1'b0;
            end
        end else if (clr) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_dig[i] <= '0;
                r_dp[i]  <= 1'b0;
            end
        end else if (load) begin
            r_dig[0] <= seg_in;
            r_dp[0]  <= dp_in;
            for (int i = 1; i < N_DIGITS; i++) begin
                r_dig[i] <= r_dig[i-1];
                r_dp[i]  <= r_dp[i-1];
            end
        end
    end

    // Registered active-low pin drive; blank slots release every anode and segment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n      <= c_seg_off;
            r_dp_n       <= c_dp_off;
            r_an_n       <= w_an_off_full[N_DIGITS-1:0];
            r_frame_tick <= 1'b0;
        end else begin
            if (w_drive) begin
                r_seg_n <= ~r_dig[w_idx];
                r_dp_n  <= ~r_dp[w_idx];
                r_an_n  <= w_an_sel_full[N_DIGITS-1:0];
            end else begin
                r_seg_n <= c_seg_off;
                r_dp_n  <= c_dp_off;
                r_an_n  <= w_an_off_full[N_DIGITS-1:0];
            end
            r_frame_tick <= w_wrap;
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Directed, table-driven bench for seg_scan_driver with
//                N_DIGITS=4, SCAN_DIV=10, BLANK_CYC=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_tick;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } pwr_vec_t;

    typedef struct {
        logic [6:0] seg_in;
        logic       dp_in;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } digit_vec_t;

    pwr_vec_t   pwr_tab [13];
    digit_vec_t dig_tab [4];

    seg_scan_driver #(
        .N_DIGITS  (4),
        .SCAN_DIV  (10),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sample on falling edges until the anode pattern matches or the budget runs out
    task automatic wait_an(input logic [3:0] target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an_n === target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(name, {28'h0, an_n}, {28'h0, target});
    endtask

    initial begin
        int n;
        int last;
        int bad_gap;
        int ticks;
        int dbl;
        int bad_off;

        checks = 0;
        errors = 0;

        // Power-up expectations per edge after reset release
        for (int e = 0; e < 13; e++) begin
            pwr_tab[e].seg = 7'h7F;
            if (e < 2)       pwr_tab[e].an = 4'hF;
            else if (e < 10) pwr_tab[e].an = 4'hE;
            else if (e < 12) pwr_tab[e].an = 4'hF;
            else             pwr_tab[e].an = 4'hD;
        end

        // Loaded values and where they end up once all four are in
        dig_tab[0] = '{seg_in: 7'h06, dp_in: 1'b0, an: 4'hE, seg: 7'h19, dp: 1'b1};
        dig_tab[1] = '{seg_in: 7'h5B, dp_in: 1'b0, an: 4'hD, seg: 7'h30, dp: 1'b0};
        dig_tab[2] = '{seg_in: 7'h4F, dp_in: 1'b1, an: 4'hB, seg: 7'h24, dp: 1'b1};
        dig_tab[3] = '{seg_in: 7'h66, dp_in: 1'b0, an: 4'h7, seg: 7'h79, dp: 1'b1};

        rst_n  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        load   = 1'b0;
        seg_in = 7'h00;
        dp_in  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg_n", {25'h0, seg_n}, 32'h7F);
        chk("rst_dp_n", {31'h0, dp_n}, 32'h1);
        chk("rst_an_n", {28'h0, an_n}, 32'hF);
        chk("rst_frame_tick", {31'h0, frame_tick}, 32'h0);

        // Release and scan from empty storage
        rst_n = 1'b1;
        en    = 1'b1;
        for (int e = 0; e < 13; e++) begin
            @(negedge clk);
            chk($sformatf("pwr_an_e%0d", e), {28'h0, an_n}, {28'h0, pwr_tab[e].an});
            chk($sformatf("pwr_seg_e%0d", e), {25'h0, seg_n}, {25'h0, pwr_tab[e].seg});
        end

        // Load four digits back to back
        for (int d = 0; d < 4; d++) begin
            load   = 1'b1;
            seg_in = dig_tab[d].seg_in;
            dp_in  = dig_tab[d].dp_in;
            @(negedge clk);
        end
        load  = 1'b0;
        dp_in = 1'b0;
        repeat (2) @(negedge clk);

        // Newest on digit 0, oldest on digit 3
        for (int d = 3; d >= 0; d--) begin
            wait_an(dig_tab[d].an, $sformatf("wait_slot_d%0d", d));
            repeat (2) @(negedge clk);
            chk($sformatf("slot_an_d%0d", d), {28'h0, an_n}, {28'h0, dig_tab[d].an});
            chk($sformatf("slot_seg_d%0d", d), {25'h0, seg_n}, {25'h0, dig_tab[d].seg});
            chk($sformatf("slot_dp_d%0d", d), {31'h0, dp_n}, {31'h0, dig_tab[d].dp});
        end

        // Free run: frame period and single-anode property
        last = -1; bad_gap = 0; ticks = 0; dbl = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (frame_tick) begin
                if (last >= 0 && (c - last) != 40) bad_gap++;
                last = c;
                ticks++;
            end
            if ($countones(~an_n) > 1) dbl++;
        end
        chk("frame_tick_count", ticks, 5);
        chk("frame_tick_gap", bad_gap, 0);
        chk("double_anode", dbl, 0);

        // Load mid-SHOW of digit 0: pattern updates, slot length unchanged
        wait_an(4'h7, "wait_d3_before_live_load");
        wait_an(4'hE, "wait_d0_live_load");
        n = 1;
        repeat (2) @(negedge clk);
        n += 2;
        load   = 1'b1;
        seg_in = 7'h3F;
        dp_in  = 1'b0;
        @(negedge clk);
        n++;
        load = 1'b0;
        chk("live_load_seg_old", {25'h0, seg_n}, 32'h19);
        @(negedge clk);
        n++;
        chk("live_load_seg_new", {25'h0, seg_n}, 32'h40);
        chk("live_load_an", {28'h0, an_n}, 32'hE);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an_n === 4'hE) n++;
            else break;
        end
        chk("live_load_slot_len", n, 8);

        // Storage now 3F,66,4F(dp),5B; disable mid-SHOW of digit 2
        wait_an(4'hB, "wait_d2_disable");
        repeat (2) @(negedge clk);
        chk("pre_dis_seg", {25'h0, seg_n}, 32'h30);
        en = 1'b0;
        @(negedge clk);
        chk("dis_an", {28'h0, an_n}, 32'hF);
        chk("dis_seg", {25'h0, seg_n}, 32'h7F);
        chk("dis_dp", {31'h0, dp_n}, 32'h1);
        bad_off = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (an_n !== 4'hF || frame_tick !== 1'b0 || seg_n !== 7'h7F) bad_off++;
        end
        chk("dis_hold_dark", bad_off, 0);
        en = 1'b1;
        @(negedge clk);
        chk("resume_blank0", {28'h0, an_n}, 32'hF);
        @(negedge clk);
        chk("resume_blank1", {28'h0, an_n}, 32'hF);
        @(negedge clk);
        chk("resume_an", {28'h0, an_n}, 32'hB);
        chk("resume_seg", {25'h0, seg_n}, 32'h30);
        chk("resume_dp", {31'h0, dp_n}, 32'h0);

        // clr together with load empties the history
        clr    = 1'b1;
        load   = 1'b1;
        seg_in = 7'h3F;
        dp_in  = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        load  = 1'b0;
        dp_in = 1'b0;
        wait_an(4'h7, "wait_d3_after_clr");
        repeat (2) @(negedge clk);
        chk("clr_seg_d3", {25'h0, seg_n}, 32'h7F);
        wait_an(4'hE, "wait_d0_after_clr");
        repeat (2) @(negedge clk);
        chk("clr_seg_d0", {25'h0, seg_n}, 32'h7F);
        chk("clr_dp_d0", {31'h0, dp_n}, 32'h1);

        // Async reset mid-SHOW
        load   = 1'b1;
        seg_in = 7'h6D;
        dp_in  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        dp_in = 1'b0;
        wait_an(4'hD, "wait_d1_before_reset");
        wait_an(4'hE, "wait_d0_before_reset");
        repeat (2) @(negedge clk);
        chk("pre_rst_seg", {25'h0, seg_n}, 32'h12);
        chk("pre_rst_dp", {31'h0, dp_n}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {28'h0, an_n}, 32'hF);
        chk("async_rst_seg", {25'h0, seg_n}, 32'h7F);
        chk("async_rst_dp", {31'h0, dp_n}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_blank0", {28'h0, an_n}, 32'hF);
        @(negedge clk);
        chk("post_rst_blank1", {28'h0, an_n}, 32'hF);
        @(negedge clk);
        chk("post_rst_an", {28'h0, an_n}, 32'hE);
        chk("post_rst_seg", {25'h0, seg_n}, 32'h7F);
        chk("post_rst_dp", {31'h0, dp_n}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
